bus_grant_sched: RTL and testbench

Round-robin bus scheduler that shares one bus among eight requesters and drives the 3-bit select of the 3-to-8 active-low enable decoder. It sits between the requesting units and the bus-enable decode. It issues one registered grant at a time, enforces a maximum hold time when other units are waiting, and inserts a dead turnaround gap between owners so that two drivers never overlap.

---
 rtl/bus_grant_sched_if.sv | 26 ++
 rtl/bus_grant_sched.sv | 138 +++++++++++++
 tb/tb_bus_grant_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_grant_sched_if.sv
// rtl/bus_grant_sched_if.sv - request/grant bundle between requesters and the bus scheduler
interface bus_grant_sched_if;
  logic [7:0] req_n;      // active-low requests, bit i is requester i
  logic [2:0] sel;        // current or most recent owner index
  logic       sel_valid;  // a grant is active
  logic [7:0] grant_n;    // active-low one-hot grant
  logic       busy;       // scheduler is in GRANT or TURN

  // scheduler side
  modport master (
    input  req_n,
    output sel,
    output sel_valid,
    output grant_n,
    output busy
  );

  // requester / decoder side
  modport slave (
    output req_n,
    input  sel,
    input  sel_valid,
    input  grant_n,
    input  busy
  );
endinterface

// File: rtl/bus_grant_sched.sv
// rtl/bus_grant_sched.sv - round-robin eight-way bus scheduler with hold limit and turnaround gap
module bus_grant_sched #(
  parameter int MAX_HOLD   = 15,  // 1..255
  parameter int TURNAROUND = 1    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  bus_grant_sched_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       sel_valid_q, sel_valid_d;
  logic [7:0] grant_n_q, grant_n_d;
  logic       busy_q, busy_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;

  logic [2:0] winner;
  logic       any_req;
  logic       owner_release;
  logic       others_pending;

  // Round-robin search starting just after the previous owner; that owner is tried last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req_n_i, input logic [2:0] last_i);
    logic [2:0] idx;
    logic       found;
    rr_pick = last_i;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_i + 3'(k);
      if (!found && !req_n_i[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Request decode: winner candidate, owner release and competing requests.
  always_comb begin
    winner         = rr_pick(bus.req_n, last_q);
    any_req        = ~(&bus.req_n);
    owner_release  = bus.req_n[sel_q];
    others_pending = |(~bus.req_n & ~(8'd1 << sel_q));
  end

  // Next-state logic; grant_n is formed from the next sel/sel_valid so it is a clean flop output.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    turn_cnt_d  = turn_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_GRANT;
          sel_d       = winner;
          last_d      = winner;
          hold_cnt_d  = 8'd0;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_GRANT: begin
        // A release coinciding with hold expiry lands in the same TURN entry.
        if (owner_release || (hold_cnt_q == HOLD_LAST && others_pending)) begin
          state_d     = ST_TURN;
          sel_valid_d = 1'b0;
          turn_cnt_d  = 4'd0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_TURN: begin
        // Requests are ignored here; arbitration resumes from IDLE.
        if (turn_cnt_q == TURN_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    grant_n_d = sel_valid_d ? ~(8'd1 << sel_d) : 8'hFF;
  end

  // State and output registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      grant_n_q   <= 8'hFF;
      busy_q      <= 1'b0;
      last_q      <= 3'd7;
      hold_cnt_q  <= 8'd0;
      turn_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      grant_n_q   <= grant_n_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.grant_n   = grant_n_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_grant_sched.sv
// tb/tb_bus_grant_sched.sv - directed and random stimulus against a behavioural scheduler model
module tb_bus_grant_sched;
  localparam int MH = 3;
  localparam int TA = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_grant_sched_if bus_if ();

  bus_grant_sched #(
    .MAX_HOLD  (MH),
    .TURNAROUND(TA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // model: current owner (-1 none), cycles it has been visible, dead cycles left, rr pointer, sel
  int m_owner, m_age, m_dead, m_last, m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_dead  = 0;
    m_last  = 7;
    m_sel   = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] others;
    bit found;
    int idx;
    if (m_owner >= 0) begin
      others = ~r;
      others[m_owner] = 1'b0;
      if (r[m_owner] || (m_age >= MH && others != 8'd0)) begin
        m_owner = -1;
        m_dead  = TA;
      end else begin
        m_age++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        idx = (m_last + k) % 8;
        if (!found && !r[idx]) begin
          found   = 1;
          m_owner = idx;
          m_age   = 1;
          m_last  = idx;
          m_sel   = idx;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] g;
    g = 8'hFF;
    if (m_owner >= 0) g[m_owner] = 1'b0;
    check({tag, ".grant_n"},   32'(bus_if.grant_n),   32'(g));
    check({tag, ".sel"},       32'(bus_if.sel),       32'(m_sel));
    check({tag, ".sel_valid"}, 32'(bus_if.sel_valid), 32'(m_owner >= 0));
    check({tag, ".busy"},      32'(bus_if.busy),      32'((m_owner >= 0) || (m_dead > 0)));
  endtask

  task automatic step(input logic [7:0] r, input string tag);
    @(negedge clk);
    bus_if.req_n = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs(tag);
  endtask

  int cnt;
  int prev_sel;
  logic prev_valid;
  logic [7:0] rnd;

  initial begin
    reset = 1'b1;
    bus_if.req_n = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.grant_n",   32'(bus_if.grant_n),   32'hFF);
    check("rst.sel",       32'(bus_if.sel),       32'h0);
    check("rst.sel_valid", 32'(bus_if.sel_valid), 32'h0);
    check("rst.busy",      32'(bus_if.busy),      32'h0);
    @(negedge clk);
    reset = 1'b0;

    // voluntary release by requester 3
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(8'hF7, "vol");
      if (bus_if.grant_n == 8'hF7) cnt++;
    end
    check("vol.cycles", 32'(cnt), 32'd4);
    for (int i = 0; i < 3; i++) step(8'hFF, "vol_idle");
    check("vol.busy_end", 32'(bus_if.busy), 32'h0);

    // request pulsing only during TURN is not granted
    step(8'hF7, "late");
    step(8'hF7, "late");
    step(8'hFF, "late_rel");
    step(8'hFD, "late_turn");
    step(8'hFF, "late_idle");
    step(8'hFF, "late_idle");
    check("late.grant_n", 32'(bus_if.grant_n), 32'hFF);

    // solo requester holds past MAX_HOLD
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(8'hBF, "solo");
      if (bus_if.grant_n == 8'hBF) cnt++;
    end
    check("solo.cycles", 32'(cnt), 32'd20);
    for (int i = 0; i < 3; i++) step(8'hFF, "solo_idle");

    // forced release alternates between requesters 2 and 4
    prev_sel = -1;
    prev_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(8'hEB, "fair");
      if (bus_if.sel_valid && !prev_valid) begin
        if (prev_sel >= 0) check("fair.alternate", 32'(bus_if.sel != 3'(prev_sel)), 32'd1);
        prev_sel = int'(bus_if.sel);
      end
      prev_valid = bus_if.sel_valid;
    end
    for (int i = 0; i < 3; i++) step(8'hFF, "fair_idle");

    // all requesting: strict rotation
    for (int i = 0; i < 48; i++) step(8'h00, "rr");
    for (int i = 0; i < 3; i++) step(8'hFF, "rr_idle");

    // asynchronous reset while requester 5 owns the bus
    step(8'hDF, "rst5");
    step(8'hDF, "rst5");
    check("rst5.sel", 32'(bus_if.sel), 32'd5);
    #1 reset = 1'b1;
    #1;
    check("arst.grant_n",   32'(bus_if.grant_n),   32'hFF);
    check("arst.sel_valid", 32'(bus_if.sel_valid), 32'h0);
    #1 reset = 1'b0;
    model_reset();
    step(8'hFE, "post_rst");
    check("post_rst.grant_n", 32'(bus_if.grant_n), 32'hFE);
    step(8'hFF, "post_rst");

    // random traffic
    rnd = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rnd = ~(8'($urandom) & 8'($urandom));
        if ($urandom_range(0, 7) == 0) rnd = 8'hFF;
      end
      step(rnd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
